// File: rtl/qif_pkg.sv
// Shared types and constants for the QIF neuron datapath.
// Combinational helpers only; no latency of its own.
// No flow control; the helpers are used inside per-clock datapaths.
package qif_pkg;

  localparam int I_W = 8;
  localparam int V_W = 8;

  typedef logic signed [I_W-1:0] cur_t;

  localparam cur_t CUR_MAX = cur_t'(127);
  localparam cur_t CUR_MIN = cur_t'(-128);

  // Clamp a wide signed value into the cur_t range.
  function automatic cur_t sat_clamp(input logic signed [31:0] x);
    cur_t r;
    if (x > 32'(CUR_MAX)) begin
      r = CUR_MAX;
    end else if (x < 32'(CUR_MIN)) begin
      r = CUR_MIN;
    end else begin
      r = x[I_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/qif_synapse_if.sv
// Spike, weight-programming and current-output bundle for qif_synapse.
// Pure wiring; no latency.
// No handshake: every spike bit present at a clock edge is consumed.
interface qif_synapse_if #(
  parameter int N_SYN = 4
);
  import qif_pkg::*;

  localparam int AW = $clog2(N_SYN);

  logic [N_SYN-1:0] spike_in;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  cur_t             w_data;
  logic             cnt_clr;
  cur_t             I_syn;
  logic             sat;
  logic [7:0]       spike_cnt;

  modport master (
    output spike_in, w_we, w_addr, w_data, cnt_clr,
    input  I_syn, sat, spike_cnt
  );

  modport slave (
    input  spike_in, w_we, w_addr, w_data, cnt_clr,
    output I_syn, sat, spike_cnt
  );

endinterface

// File: rtl/qif_weight_rf.sv
// Signed weight file with one write port and a combinational spike-masked sum.
// Write takes effect at the clock edge; wsum_o is combinational from current weights.
// No backpressure; a write is accepted every cycle it is enabled.
module qif_weight_rf
  import qif_pkg::*;
#(
  parameter  int N_SYN = 4,
  localparam int AW    = $clog2(N_SYN),
  localparam int SW    = I_W + AW + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  cur_t                 data_i,
  input  logic [N_SYN-1:0]     spike_i,
  output logic signed [SW-1:0] wsum_o
);

  cur_t w_q [N_SYN];

  // Weight storage; cleared by reset, so weights must be reprogrammed after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYN; i++) begin
        w_q[i] <= '0;
      end
    end else if (we_i) begin
      w_q[addr_i] <= data_i;
    end
  end

  // Sum of the weights whose spike bit is set; reads pre-write values.
  always_comb begin
    wsum_o = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (spike_i[i]) begin
        wsum_o = wsum_o + {{(SW-I_W){w_q[i][I_W-1]}}, w_q[i]};
      end
    end
  end

endmodule

// File: rtl/qif_synapse.sv
// Weighted spike integration into an exponentially decaying, saturated current.
// One-cycle latency: a spike sampled at edge n is visible on I_syn after edge n.
// No backpressure; all spikes and writes are consumed at every clock edge.
module qif_synapse
  import qif_pkg::*;
#(
  parameter int N_SYN       = 4,
  parameter int DECAY_SHIFT = 2
) (
  input logic           clk,
  input logic           rst_n,
  qif_synapse_if.slave  bus
);

  localparam int AW = $clog2(N_SYN);
  localparam int SW = I_W + AW + 2;
  localparam int PW = AW + 1;
  localparam logic signed [SW-1:0] NXT_MAX = SW'(CUR_MAX);
  localparam logic signed [SW-1:0] NXT_MIN = SW'(CUR_MIN);

  cur_t                 i_syn_q, i_syn_d;
  logic                 sat_q, sat_d;
  logic [7:0]           cnt_q, cnt_d;
  logic signed [SW-1:0] wsum;
  logic signed [SW-1:0] nxt;
  cur_t                 decay;
  logic [PW-1:0]        pop;
  logic [8:0]           cnt_sum;

  qif_weight_rf #(.N_SYN(N_SYN)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.w_we),
    .addr_i  (bus.w_addr),
    .data_i  (bus.w_data),
    .spike_i (bus.spike_in),
    .wsum_o  (wsum)
  );

  // Decay term; a positive current always loses at least 1 so it reaches zero.
  always_comb begin
    decay = i_syn_q >>> DECAY_SHIFT;
    if (!i_syn_q[I_W-1] && (i_syn_q != '0) && (decay == '0)) begin
      decay = cur_t'(1);
    end
  end

  // Next current at full width, then clamp and flag any clipping.
  always_comb begin
    nxt = {{(SW-I_W){i_syn_q[I_W-1]}}, i_syn_q}
        - {{(SW-I_W){decay[I_W-1]}}, decay}
        + wsum;
    i_syn_d = sat_clamp(32'(nxt));
    sat_d   = (nxt > NXT_MAX) || (nxt < NXT_MIN);
  end

  // Number of spikes arriving this cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SYN; i++) begin
      pop = pop + PW'(bus.spike_in[i]);
    end
  end

  // Saturating spike counter; clear wins and drops this cycle's spikes.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 9'(pop);
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_sum[8]) begin
      cnt_d = 8'hFF;
    end else begin
      cnt_d = cnt_sum[7:0];
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_syn_q <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      i_syn_q <= i_syn_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.I_syn     = i_syn_q;
  assign bus.sat       = sat_q;
  assign bus.spike_cnt = cnt_q;

endmodule

// File: tb/tb_qif_synapse.sv
// Bench for qif_synapse: directed scenarios plus random traffic against a reference model.
module tb_qif_synapse;
  import qif_pkg::*;

  localparam int N_SYN = 4;
  localparam int DS    = 2;
  localparam int AW    = $clog2(N_SYN);

  logic clk = 1'b0;
  logic rst_n;

  qif_synapse_if #(.N_SYN(N_SYN)) bus ();

  qif_synapse #(.N_SYN(N_SYN), .DECAY_SHIFT(DS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers.
  int m_w [N_SYN];
  int m_i;
  int m_sat;
  int m_cnt;

  int dec_tab [15] = '{40, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_SYN; i++) m_w[i] = 0;
    m_i   = 0;
    m_sat = 0;
    m_cnt = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic [N_SYN-1:0] spk, input logic we,
                            input int addr, input int data, input logic clr);
    int wsum;
    int pc;
    int d;
    int nxt;
    wsum = 0;
    pc   = 0;
    for (int i = 0; i < N_SYN; i++) begin
      if (spk[i]) begin
        wsum += m_w[i];
        pc++;
      end
    end
    d = m_i >>> DS;
    if (m_i > 0 && d == 0) d = 1;
    nxt   = m_i - d + wsum;
    m_sat = (nxt > 127 || nxt < -128) ? 1 : 0;
    m_i   = (nxt > 127) ? 127 : ((nxt < -128) ? -128 : nxt);
    if (clr) m_cnt = 0;
    else     m_cnt = (m_cnt + pc > 255) ? 255 : m_cnt + pc;
    if (we) m_w[addr] = data;
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic cyc(input logic [N_SYN-1:0] spk, input logic we,
                     input int addr, input int data, input logic clr);
    bus.spike_in = spk;
    bus.w_we     = we;
    bus.w_addr   = AW'(addr);
    bus.w_data   = cur_t'(data);
    bus.cnt_clr  = clr;
    model_edge(spk, we, addr, data, clr);
    @(posedge clk);
    #1;
    check("I_syn", bus.I_syn, m_i);
    check("sat", bus.sat, m_sat);
    check("spike_cnt", bus.spike_cnt, m_cnt);
  endtask

  task automatic idle_to_zero();
    for (int k = 0; k < 40 && m_i != 0; k++) cyc('0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int c0;
    bus.spike_in = '0;
    bus.w_we     = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    bus.cnt_clr  = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_I_syn", bus.I_syn, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_cnt", bus.spike_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Build I_syn = 30, spike_cnt = 7, then reset asynchronously mid-cycle.
    cyc('0, 1'b1, 0, 30, 1'b0);
    cyc(4'b1110, 1'b0, 0, 0, 1'b0);
    cyc(4'b1110, 1'b0, 0, 0, 1'b0);
    cyc(4'b0001, 1'b0, 0, 0, 1'b0);
    check("pre_rst_I", bus.I_syn, 30);
    check("pre_rst_cnt", bus.spike_cnt, 7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_I", bus.I_syn, 0);
    check("async_rst_cnt", bus.spike_cnt, 0);
    bus.spike_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0001, 1'b0, 0, 0, 1'b0);
    check("w_lost_after_rst", bus.I_syn, 0);

    // Single-spike decay trajectory.
    cyc('0, 1'b1, 0, 40, 1'b0);
    for (int k = 0; k < 15; k++) begin
      cyc((k == 0) ? 4'b0001 : 4'b0000, 1'b0, 0, 0, 1'b0);
      check("decay_seq", bus.I_syn, dec_tab[k]);
      check("decay_no_sat", bus.sat, 0);
    end
    cyc('0, 1'b0, 0, 0, 1'b0);
    check("decay_hold0", bus.I_syn, 0);

    // Positive saturation.
    for (int a = 0; a < N_SYN; a++) cyc('0, 1'b1, a, 100, 1'b0);
    c0 = m_cnt;
    cyc(4'b1111, 1'b0, 0, 0, 1'b0);
    check("pos_sat_I", bus.I_syn, 127);
    check("pos_sat_flag", bus.sat, 1);
    check("pos_sat_cnt", bus.spike_cnt, c0 + 4);
    cyc('0, 1'b0, 0, 0, 1'b0);
    check("pos_sat_pulse", bus.sat, 0);

    // Negative saturation.
    idle_to_zero();
    cyc('0, 1'b1, 1, -128, 1'b0);
    cyc(4'b0010, 1'b0, 0, 0, 1'b0);
    check("neg1_I", bus.I_syn, -128);
    check("neg1_sat", bus.sat, 0);
    cyc(4'b0010, 1'b0, 0, 0, 1'b0);
    check("neg2_I", bus.I_syn, -128);
    check("neg2_sat", bus.sat, 1);
    cyc('0, 1'b0, 0, 0, 1'b0);
    check("neg_decay_I", bus.I_syn, -96);
    check("neg_decay_sat", bus.sat, 0);

    // Write/spike collision on the same index.
    idle_to_zero();
    cyc('0, 1'b1, 2, 10, 1'b0);
    cyc(4'b0100, 1'b1, 2, 50, 1'b0);
    check("coll_old_w", bus.I_syn, 10);
    cyc(4'b0100, 1'b0, 0, 0, 1'b0);
    check("coll_new_w", bus.I_syn, 58);

    // Counter saturation and clear priority.
    for (int k = 0; k < 70; k++) cyc(4'b1111, 1'b0, 0, 0, 1'b0);
    check("cnt_sat", bus.spike_cnt, 255);
    cyc(4'b1111, 1'b0, 0, 0, 1'b1);
    check("cnt_clr", bus.spike_cnt, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cyc(N_SYN'($urandom_range(0, (1 << N_SYN) - 1)),
          ($urandom_range(0, 3) == 0),
          $urandom_range(0, N_SYN - 1),
          int'($urandom_range(0, 255)) - 128,
          ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qif_synapse.md
# qif_synapse

Upstream synaptic-current stage for the QIF neuron. Accepts per-cycle presynaptic spike pulses on `N_SYN` inputs, weights each with a programmable signed 8-bit weight, and integrates them into an exponentially decaying current. The registered, saturated 8-bit signed result drives the neuron's `I_syn` input directly, one update per clock, matching the neuron's per-clock integration.

## Interface
- `N_SYN`, default 4: number of presynaptic inputs, power of two, 2..16.
- `DECAY_SHIFT`, default 2: decay per cycle is I >>> DECAY_SHIFT, with a minimum magnitude of 1 for positive I. Range 1..6.
- `clk  in  1`: single clock; all state updates on posedge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `spike_in  in  N_SYN`: one-cycle spike pulses, one bit per synapse; multiple bits may be set in the same cycle.
- `w_we  in  1`: weight write enable.
- `w_addr  in  clog2(N_SYN)`: weight index.
- `w_data  in  8`: signed weight value.
- `cnt_clr  in  1`: synchronous clear of `spike_cnt`.
- `I_syn  out  8`: signed synaptic current, registered; feeds the neuron.
- `sat  out  1`: one-cycle pulse when the current update clipped.
- `spike_cnt  out  8`: saturating count of input spikes (popcount per cycle).

## Operation
- Weight file: `N_SYN` signed 8-bit registers. A write sets `w[w_addr] = w_data` on posedge when `w_we` is high.
- Per cycle, the block computes `wsum` = the signed sum of `w[i]` for every i with `spike_in[i]` high.
  - `wsum` uses the weight values before any same-edge write.
- Decay term `d` = I_syn >>> DECAY_SHIFT (arithmetic shift). If I_syn > 0 and `d` == 0, then `d` = 1.
  - Result: positive current decays to 0. Negative current reaches 0 because -1 >>> k = -1.
- Next-value computation: `nxt` = I_syn − d + wsum.
  - Internal width is 8 + clog2(N_SYN) + 2 bits, signed, with no intermediate overflow.
- Saturation: `nxt` is clamped to the range [−128, +127].
  - `sat` = 1 in the cycle the clamped value is registered if clamping occurred, otherwise 0.
- Spike counter: `spike_cnt` += popcount(spike_in) each cycle, saturating at 255.
  - `cnt_clr` has priority: the counter loads 0, and spikes arriving in that cycle are discarded from the count.
- There is no handshake; every spike bit present at a posedge is consumed at that edge.
  - Spikes held high for k cycles count k times.

## Timing
- Reset (rst_n low, asynchronous): I_syn = 0, sat = 0, spike_cnt = 0, all weights = 0.
- Reset release is synchronous to the next posedge. No spike or write is taken during the cycle in which rst_n is low.
- Latency: a spike sampled at posedge n appears in I_syn after posedge n, so the neuron sees it at posedge n+1.
- Write/spike collision on the same index: the old weight is used; the new weight applies from the next cycle.
- Reset mid-operation: I_syn and the counter drop to 0 immediately; weights are lost and must be reprogrammed.
- With no spikes and no writes, I_syn is monotone toward 0 and stays at 0.

## Structure
- Shared package `qif_pkg` holds:
  - `I_W` = 8, `V_W` = 8;
  - typedef `cur_t` (signed [I_W-1:0]);
  - constants `CUR_MAX` = 127, `CUR_MIN` = −128;
  - a saturating-clamp function reused by the neuron.
- One sub-module, `qif_weight_rf`: the weight register file, with write port and combinational masked weighted sum `wsum`.
- The top level holds the decay, clamp, `sat`, and counter logic.

## Test plan
- Reset: drive rst_n low mid-run with I_syn = 30 and spike_cnt = 7 -> both read 0 before the next clock edge; the weights read back as zero effect (a spike yields I_syn = 0).
- Single-spike decay (DECAY_SHIFT = 2): write w0 = 40, pulse spike_in = 0001 -> I_syn sequence 40, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0, then holds 0; sat never asserts.
- Positive saturation: w0..w3 = 100, spike_in = 1111 one cycle -> I_syn = 127, sat = 1 for exactly one cycle, spike_cnt += 4.
- Negative saturation: w1 = −128, spike_in = 0010 on two consecutive cycles -> I_syn = −128 then −128 (−224 clamped), sat = 0 then 1; with no further spikes, next value −96.
- Write/spike collision: w2 = 10; in one cycle, write w2 = 50 together with spike_in = 0100 -> I_syn = 10. Next cycle spike_in = 0100 -> I_syn = 10 − 2 + 50 = 58.
- Counter: hold spike_in = 1111 for 70 cycles -> spike_cnt saturates at 255. Assert cnt_clr together with spike_in = 1111 -> spike_cnt = 0.
